// File: rtl/decode_stage.sv
// decode_stage: registered RV32I instruction-decode stage.
//
// Takes one instruction per cycle from fetch over a valid/ready handshake,
// classifies it by opcode, extracts register indices, an immediate-format code
// and a packed raw immediate, and presents everything registered downstream.
// A main register drives the outputs; a single skid register absorbs the one
// extra instruction that arrives in the cycle backpressure first appears, so
// in_ready never depends combinationally on out_ready.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   flush        synchronous squash of every held instruction
//   in_valid     upstream instruction valid
//   in_ready     stage can accept (skid register empty)
//   in_inst      32-bit instruction word
//   in_pc        32-bit instruction address
//   out_valid    decoded instruction valid
//   out_ready    downstream accepts
//   out_inst     registered instruction word
//   out_pc       registered PC
//   out_rd       inst[11:7]
//   out_rs1      inst[19:15]
//   out_rs2      inst[24:20]
//   out_imm_fmt  immediate format: 000 none, 001 I/S, 010 J, 011 B, 100 U
//   out_imm      packed raw immediate, unused upper bits zero
//   out_illegal  opcode not recognised
module decode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [2:0]  out_imm_fmt,
  output logic [20:0] out_imm,
  output logic        out_illegal
);

  localparam logic [2:0] FMT_NONE = 3'b000;
  localparam logic [2:0] FMT_IS   = 3'b001;
  localparam logic [2:0] FMT_J    = 3'b010;
  localparam logic [2:0] FMT_B    = 3'b011;
  localparam logic [2:0] FMT_U    = 3'b100;

  // One decoded instruction as held in either buffer register.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  fmt;
    logic [20:0] imm;
    logic        illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] inst, input logic [31:0] pc);
    dec_t d;
    d.inst    = inst;
    d.pc      = pc;
    d.rd      = inst[11:7];
    d.rs1     = inst[19:15];
    d.rs2     = inst[24:20];
    d.fmt     = FMT_NONE;
    d.imm     = 21'd0;
    d.illegal = 1'b0;
    case (inst[6:0])
      // OP-IMM, LOAD, JALR, MISC-MEM, SYSTEM: plain 12-bit I immediate
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        d.fmt = FMT_IS;
        d.imm = {9'd0, inst[31:20]};
      end
      // STORE: immediate split around rs2/rs1
      7'b0100011: begin
        d.fmt = FMT_IS;
        d.imm = {9'd0, inst[31:25], inst[11:7]};
      end
      // BRANCH: offset bits 12:1, bit 0 is implicit
      7'b1100011: begin
        d.fmt = FMT_B;
        d.imm = {9'd0, inst[31], inst[7], inst[30:25], inst[11:8]};
      end
      // JAL: offset bits 20:1
      7'b1101111: begin
        d.fmt = FMT_J;
        d.imm = {1'b0, inst[31], inst[19:12], inst[20], inst[30:21]};
      end
      // LUI, AUIPC: upper 20 bits
      7'b0110111, 7'b0010111: begin
        d.fmt = FMT_U;
        d.imm = {1'b0, inst[31:12]};
      end
      // OP: register-register, no immediate
      7'b0110011: begin
        d.fmt = FMT_NONE;
        d.imm = 21'd0;
      end
      default: begin
        d.fmt     = FMT_NONE;
        d.imm     = 21'd0;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

  dec_t main_r;
  dec_t skid_r;
  logic main_valid_r;
  logic skid_valid_r;
  logic in_ready_r;

  dec_t dec_s;
  dec_t main_nxt_s;
  dec_t skid_nxt_s;
  logic main_valid_nxt_s;
  logic skid_valid_nxt_s;
  logic accept_s;
  logic drain_s;

  // Decode the incoming word and form the handshake qualifiers.
  always_comb begin
    dec_s    = decode(in_inst, in_pc);
    accept_s = in_valid & in_ready_r;
    drain_s  = main_valid_r & out_ready;
  end

  // Next state of the main/skid pair. When main frees up, a held skid entry
  // always moves first so ordering is preserved; in_ready is low in that
  // cycle so no new instruction competes with it.
  always_comb begin
    main_nxt_s       = main_r;
    skid_nxt_s       = skid_r;
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    if (flush) begin
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (!main_valid_r || drain_s) begin
      if (skid_valid_r) begin
        main_nxt_s       = skid_r;
        main_valid_nxt_s = 1'b1;
        skid_valid_nxt_s = 1'b0;
      end else if (accept_s) begin
        main_nxt_s       = dec_s;
        main_valid_nxt_s = 1'b1;
      end else begin
        main_valid_nxt_s = 1'b0;
      end
    end else begin
      if (accept_s) begin
        skid_nxt_s       = dec_s;
        skid_valid_nxt_s = 1'b1;
      end else begin
        skid_valid_nxt_s = skid_valid_r;
      end
    end
  end

  // Buffer registers; in_ready is kept as its own flop mirroring skid-empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
    end else begin
      main_r       <= main_nxt_s;
      skid_r       <= skid_nxt_s;
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= ~skid_valid_nxt_s;
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = main_valid_r;
  assign out_inst    = main_r.inst;
  assign out_pc      = main_r.pc;
  assign out_rd      = main_r.rd;
  assign out_rs1     = main_r.rs1;
  assign out_rs2     = main_r.rs2;
  assign out_imm_fmt = main_r.fmt;
  assign out_imm     = main_r.imm;
  assign out_illegal = main_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: table of decode vectors plus handshake,
// backpressure, flush and reset sequences, checked through a scoreboard queue.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_imm_fmt;
  logic [20:0] out_imm;
  logic        out_illegal;

  decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_inst     (in_inst),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_inst    (out_inst),
    .out_pc      (out_pc),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_imm_fmt (out_imm_fmt),
    .out_imm     (out_imm),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  fmt;
    logic [20:0] imm;
    logic        ill;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];
  vec_t sb_q [$];
  vec_t cur_exp;
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] inst, input int idx, input int rd, input int rs1,
                              input int rs2, input int fmt, input logic [20:0] imm, input logic ill);
    vec_t v;
    v.inst = inst;
    v.pc   = 32'h100 + 32'(idx * 4);
    v.rd   = 5'(rd);
    v.rs1  = 5'(rs1);
    v.rs2  = 5'(rs2);
    v.fmt  = 3'(fmt);
    v.imm  = imm;
    v.ill  = ill;
    return v;
  endfunction

  task automatic drive(input int idx, input logic v);
    in_inst  = vecs[idx].inst;
    in_pc    = vecs[idx].pc;
    cur_exp  = vecs[idx];
    in_valid = v;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) cyc();
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  // Scoreboard: pop and compare on each output transfer, push on each accept.
  always @(negedge clk) begin
    vec_t e;
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%h expected=none", out_inst);
        end else begin
          e = sb_q.pop_front();
          popped++;
          chk("out_inst", out_inst, e.inst);
          chk("out_pc", out_pc, e.pc);
          chk("out_rd", 32'(out_rd), 32'(e.rd));
          chk("out_rs1", 32'(out_rs1), 32'(e.rs1));
          chk("out_rs2", 32'(out_rs2), 32'(e.rs2));
          chk("out_imm_fmt", 32'(out_imm_fmt), 32'(e.fmt));
          chk("out_imm", 32'(out_imm), 32'(e.imm));
          chk("out_illegal", 32'(out_illegal), 32'(e.ill));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(cur_exp);
    end
  end

  initial begin
    int idx;
    int c;
    int p0;

    vecs[0]  = mk(32'hFFF00093, 0, 1, 0, 31, 1, 21'h00FFF, 1'b0);  // addi x1,x0,-1
    vecs[1]  = mk(32'h00112623, 1, 12, 2, 1, 1, 21'h0000C, 1'b0);  // sw x1,12(x2)
    vecs[2]  = mk(32'hFE000EE3, 2, 29, 0, 0, 3, 21'h00FFE, 1'b0);  // beq x0,x0,-4
    vecs[3]  = mk(32'h123452B7, 3, 5, 8, 3, 4, 21'h12345, 1'b0);   // lui x5,0x12345
    vecs[4]  = mk(32'h0000006F, 4, 0, 0, 0, 2, 21'h00000, 1'b0);   // jal x0,0
    vecs[5]  = mk(32'h0000007F, 5, 0, 0, 0, 0, 21'h00000, 1'b1);   // illegal
    vecs[6]  = mk(32'h00822183, 6, 3, 4, 8, 1, 21'h00008, 1'b0);   // lw x3,8(x4)
    vecs[7]  = mk(32'hABCDE397, 7, 7, 27, 28, 4, 21'hABCDE, 1'b0); // auipc x7
    vecs[8]  = mk(32'h00C58533, 8, 10, 11, 12, 0, 21'h00000, 1'b0);// add x10,x11,x12
    vecs[9]  = mk(32'h001000EF, 9, 1, 0, 1, 2, 21'h00400, 1'b0);   // jal x1,2048
    vecs[10] = mk(32'h00209863, 10, 16, 1, 2, 3, 21'h00008, 1'b0); // bne x1,x2,16
    vecs[11] = mk(32'h00000073, 11, 0, 0, 0, 1, 21'h00000, 1'b0);  // ecall
    vecs[12] = mk(32'h0000000B, 12, 0, 0, 0, 0, 21'h00000, 1'b1);  // custom-0, illegal

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'd0; in_pc = 32'd0; cur_exp = vecs[0];
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_inst", out_inst, 32'd0);
    chk("reset_out_imm", 32'(out_imm), 32'd0);
    #11 rst = 1'b0;

    // Table: one vector per cycle, output visible one edge after acceptance.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      cyc();
      if (i > 0) chk("latency_inst", out_inst, vecs[i-1].inst);
      drive(i, 1'b1);
    end
    cyc();
    chk("latency_inst", out_inst, vecs[NV-1].inst);
    in_valid = 1'b0;
    wait_drain("table_drain");

    // Stream 8 with a 3-cycle backpressure window.
    p0 = popped; idx = 0; c = 0;
    while (idx < 8 && c < 40) begin
      cyc();
      out_ready = !(c >= 3 && c < 6);
      drive(idx, 1'b1);
      @(negedge clk);
      if (c == 3) chk("in_ready_at_drop", 32'(in_ready), 32'd1);
      if (c == 4) chk("in_ready_after_drop", 32'(in_ready), 32'd0);
      if (in_ready) idx++;
      c++;
    end
    chk("stream_accepted", 32'(idx), 32'd8);
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("stream_drain");
    chk("stream_count", 32'(popped - p0), 32'd8);

    // Fill main and skid, then flush with a same-cycle input.
    out_ready = 1'b0;
    cyc(); drive(0, 1'b1);
    cyc(); drive(1, 1'b1);
    cyc();
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_held_inst", out_inst, vecs[0].inst);
    drive(2, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("post_flush_quiet", 32'(out_valid), 32'd0);
    end

    // Flush on an empty stage only drops the same-cycle input.
    drive(3, 1'b1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_empty_out_valid", 32'(out_valid), 32'd0);
    chk("flush_empty_in_ready", 32'(in_ready), 32'd1);

    // Asynchronous reset while an instruction is held.
    out_ready = 1'b0;
    drive(3, 1'b1);
    cyc();
    in_valid = 1'b0;
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    chk("pre_reset_pc", out_pc, vecs[3].pc);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_inst", out_inst, 32'd0);
    chk("async_rst_out_pc", out_pc, 32'd0);
    chk("async_rst_out_imm", 32'(out_imm), 32'd0);
    chk("async_rst_out_fmt", 32'(out_imm_fmt), 32'd0);
    chk("async_rst_out_rd", 32'(out_rd), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    drive(7, 1'b1);
    #3 rst = 1'b0;
    sb_q.push_back(vecs[7]);
    cyc();
    in_valid = 1'b0;
    chk("first_after_rst_valid", 32'(out_valid), 32'd1);
    chk("first_after_rst_inst", out_inst, vecs[7].inst);
    wait_drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
